// File: rtl/minicpu_ctrl_pkg.sv
// Shared types and constants for the minicpu multicycle control path.
// BNEEX is always encoded so state numbering is identical across builds.
package minicpu_ctrl_pkg;

  typedef enum logic [3:0] {
    RESET   = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    MEMADR  = 4'd3,
    MEMRD   = 4'd4,
    MEMWB   = 4'd5,
    MEMWR   = 4'd6,
    RTYPEEX = 4'd7,
    RTYPEWB = 4'd8,
    BEQEX   = 4'd9,
    ADDIEX  = 4'd10,
    ADDIWB  = 4'd11,
    JEX     = 4'd12,
    BNEEX   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

endpackage

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle minicpu (fetch/decode/execute/mem/wb).
// Define MULTICYCLE_CTRL_BNE_EN to make bne (000101) a legal opcode.
module multicycle_controller
  import minicpu_ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic       illegal_op
);

  state_t state_q, state_d;
  logic   pc_write;
  logic   branch;
  logic   branch_ne;
  logic   mem_rdy;

  assign mem_rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = FETCH;
    pc_write   = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    pc_src     = PCSRC_ALU;
    alu_op     = ALUOP_ADD;
    illegal_op = 1'b0;
    case (state_q)
      RESET: state_d = FETCH;
      FETCH: begin
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_rdy;
        pc_write  = mem_rdy;
        state_d   = mem_rdy ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = SRCB_IMM2;
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
`ifdef MULTICYCLE_CTRL_BNE_EN
          OP_BNE:       state_d = BNEEX;
`endif
          default: begin
            state_d    = FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = mem_rdy ? MEMWB : MEMRD;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        state_d   = mem_rdy ? FETCH : MEMWR;
      end
      RTYPEEX: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        state_d   = RTYPEWB;
      end
      RTYPEWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BEQEX: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = PCSRC_OUT;
        branch    = 1'b1;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = ADDIWB;
      end
      ADDIWB: reg_write = 1'b1;
      JEX: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
      end
`ifdef MULTICYCLE_CTRL_BNE_EN
      BNEEX: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = PCSRC_OUT;
        branch_ne = 1'b1;
      end
`endif
      default: state_d = FETCH;
    endcase
  end

  assign pc_en = pc_write | (branch & zero) | (branch_ne & ~zero);

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected output
// vectors are queued by the driver and checked by an independent monitor.
module tb_multicycle_controller;

  typedef enum {
    T_RESET, T_FETCH, T_DECODE, T_MEMADR, T_MEMRD, T_MEMWB, T_MEMWR,
    T_RTYPEEX, T_RTYPEWB, T_BEQEX, T_ADDIEX, T_ADDIWB, T_JEX, T_BNEEX
  } tst_t;

  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       illegal_op;
  } outv_t;

  localparam logic [5:0] C_R    = 6'b000000;
  localparam logic [5:0] C_LW   = 6'b100011;
  localparam logic [5:0] C_SW   = 6'b101011;
  localparam logic [5:0] C_BEQ  = 6'b000100;
  localparam logic [5:0] C_BNE  = 6'b000101;
  localparam logic [5:0] C_ADDI = 6'b001000;
  localparam logic [5:0] C_J    = 6'b000010;
  localparam logic [5:0] C_BAD  = 6'b111111;

`ifdef MULTICYCLE_CTRL_BNE_EN
  localparam bit BNE_ON = 1'b1;
`else
  localparam bit BNE_ON = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  outv_t      act;

  int chk_cnt;
  int pass_cnt;
  outv_t exp_q[$];

  multicycle_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (act.pc_en),
    .iord       (act.iord),
    .mem_write  (act.mem_write),
    .ir_write   (act.ir_write),
    .reg_write  (act.reg_write),
    .reg_dst    (act.reg_dst),
    .mem_to_reg (act.mem_to_reg),
    .alu_src_a  (act.alu_src_a),
    .alu_src_b  (act.alu_src_b),
    .pc_src     (act.pc_src),
    .alu_op     (act.alu_op),
    .illegal_op (act.illegal_op)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit legal(input logic [5:0] op);
    legal = (op == C_R) || (op == C_LW) || (op == C_SW) ||
            (op == C_BEQ) || (op == C_ADDI) || (op == C_J) ||
            (BNE_ON && op == C_BNE);
  endfunction

  // Output table written straight from the state/output listing
  function automatic outv_t exp_out(input tst_t st, input logic [5:0] op,
                                    input logic z, input logic mr);
    outv_t e;
    e = '0;
    case (st)
      T_FETCH: begin
        e.alu_src_b = 2'b01;
        e.ir_write  = mr;
        e.pc_en     = mr;
      end
      T_DECODE: begin
        e.alu_src_b  = 2'b11;
        e.illegal_op = !legal(op);
      end
      T_MEMADR, T_ADDIEX: begin
        e.alu_src_a = 1'b1;
        e.alu_src_b = 2'b10;
      end
      T_MEMRD: e.iord = 1'b1;
      T_MEMWB: begin
        e.reg_write  = 1'b1;
        e.mem_to_reg = 1'b1;
      end
      T_MEMWR: begin
        e.iord      = 1'b1;
        e.mem_write = 1'b1;
      end
      T_RTYPEEX: begin
        e.alu_src_a = 1'b1;
        e.alu_op    = 2'b10;
      end
      T_RTYPEWB: begin
        e.reg_write = 1'b1;
        e.reg_dst   = 1'b1;
      end
      T_BEQEX, T_BNEEX: begin
        e.alu_src_a = 1'b1;
        e.alu_op    = 2'b01;
        e.pc_src    = 2'b01;
        e.pc_en     = (st == T_BEQEX) ? z : ~z;
      end
      T_ADDIWB: e.reg_write = 1'b1;
      T_JEX: begin
        e.pc_src = 2'b10;
        e.pc_en  = 1'b1;
      end
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic cyc(input tst_t st, input logic [5:0] op,
                     input logic z, input logic mr);
    @(posedge clk);
    #1;
    opcode    = op;
    zero      = z;
    mem_ready = mr;
    exp_q.push_back(exp_out(st, op, z, mr));
  endtask

  task automatic check(input string name, input outv_t got, input outv_t want);
    chk_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s got %h want %h", name, got, want);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      outv_t e;
      e = exp_q.pop_front();
      check($sformatf("cycle@%0t", $time), act, e);
    end
  end

  initial begin
    chk_cnt   = 0;
    pass_cnt  = 0;
    rst_n     = 1'b0;
    opcode    = C_R;
    zero      = 1'b0;
    mem_ready = 1'b1;

    cyc(T_RESET, C_LW, 1'b0, 1'b1);
    rst_n = 1'b1;

    // lw, no waits
    cyc(T_FETCH,  C_LW, 1'b0, 1'b1);
    cyc(T_DECODE, C_LW, 1'b0, 1'b1);
    cyc(T_MEMADR, C_LW, 1'b0, 1'b1);
    cyc(T_MEMRD,  C_LW, 1'b0, 1'b1);
    cyc(T_MEMWB,  C_LW, 1'b0, 1'b1);

    // sw with three wait cycles
    cyc(T_FETCH,  C_SW, 1'b0, 1'b1);
    cyc(T_DECODE, C_SW, 1'b0, 1'b1);
    cyc(T_MEMADR, C_SW, 1'b0, 1'b1);
    cyc(T_MEMWR,  C_SW, 1'b0, 1'b0);
    cyc(T_MEMWR,  C_SW, 1'b0, 1'b0);
    cyc(T_MEMWR,  C_SW, 1'b0, 1'b0);
    cyc(T_MEMWR,  C_SW, 1'b0, 1'b1);

    // R-type with a stalled fetch
    cyc(T_FETCH,   C_R, 1'b0, 1'b0);
    cyc(T_FETCH,   C_R, 1'b0, 1'b1);
    cyc(T_DECODE,  C_R, 1'b0, 1'b1);
    cyc(T_RTYPEEX, C_R, 1'b0, 1'b1);
    cyc(T_RTYPEWB, C_R, 1'b0, 1'b1);

    // beq taken and not taken
    cyc(T_FETCH,  C_BEQ, 1'b0, 1'b1);
    cyc(T_DECODE, C_BEQ, 1'b0, 1'b1);
    cyc(T_BEQEX,  C_BEQ, 1'b1, 1'b1);
    cyc(T_FETCH,  C_BEQ, 1'b0, 1'b1);
    cyc(T_DECODE, C_BEQ, 1'b1, 1'b1);
    cyc(T_BEQEX,  C_BEQ, 1'b0, 1'b1);

    // addi, j
    cyc(T_FETCH,  C_ADDI, 1'b0, 1'b1);
    cyc(T_DECODE, C_ADDI, 1'b0, 1'b1);
    cyc(T_ADDIEX, C_ADDI, 1'b0, 1'b1);
    cyc(T_ADDIWB, C_ADDI, 1'b0, 1'b1);
    cyc(T_FETCH,  C_J, 1'b0, 1'b1);
    cyc(T_DECODE, C_J, 1'b0, 1'b1);
    cyc(T_JEX,    C_J, 1'b0, 1'b1);

    // illegal opcode
    cyc(T_FETCH,  C_BAD, 1'b0, 1'b1);
    cyc(T_DECODE, C_BAD, 1'b0, 1'b1);

    // bne, zero=0 then zero=1
    for (int k = 0; k < 2; k++) begin
      logic zz;
      zz = (k == 1);
      cyc(T_FETCH,  C_BNE, zz, 1'b1);
      cyc(T_DECODE, C_BNE, zz, 1'b1);
      if (BNE_ON) cyc(T_BNEEX, C_BNE, zz, 1'b1);
    end

    // lw with one stalled read
    cyc(T_FETCH,  C_LW, 1'b0, 1'b1);
    cyc(T_DECODE, C_LW, 1'b0, 1'b1);
    cyc(T_MEMADR, C_LW, 1'b0, 1'b1);
    cyc(T_MEMRD,  C_LW, 1'b0, 1'b0);
    cyc(T_MEMRD,  C_LW, 1'b0, 1'b1);
    cyc(T_MEMWB,  C_LW, 1'b0, 1'b1);

    // reset asserted in the middle of a stalled store
    cyc(T_FETCH,  C_SW, 1'b0, 1'b1);
    cyc(T_DECODE, C_SW, 1'b0, 1'b1);
    cyc(T_MEMADR, C_SW, 1'b0, 1'b1);
    cyc(T_MEMWR,  C_SW, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", act, '0);
    cyc(T_RESET, C_R, 1'b0, 1'b1);
    rst_n = 1'b1;
    cyc(T_FETCH,  C_R, 1'b0, 1'b1);
    cyc(T_DECODE, C_R, 1'b0, 1'b1);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      chk_cnt++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
